// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative divider family.
// Used by the sequential divider and its future multi-lane/signed variants.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division iteration, purely combinational.
// Reused by the sequential divider and a future unrolled variant.
module divider_step #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] den_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_i, q_i[WIDTH-1]};
  assign trial   = shifted - {1'b0, den_i};

  // rem < den always holds, so the dropped top bit is zero in both branches
  always_comb begin
    rem_o = shifted[WIDTH-1:0];
    q_o   = {q_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock,
// with valid/ready handshakes and an explicit divide-by-zero flag.
module divider_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  divider_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i(rem_q),
    .q_i  (q_q),
    .den_i(den_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    den_d   = den_q;
    q_d     = q_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          den_d = denominator;
          dz_d  = (denominator == '0);
          if (denominator == '0) begin
            q_d     = '1;
            rem_d   = numerator;
            state_d = DONE;
          end else begin
            q_d     = numerator;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        q_d   = step_q;
        rem_d = step_rem;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      den_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      den_q   <= den_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: a 24-bit and an 8-bit instance.
// Expected results are queued at accept and popped at result handshake.
module tb_divider_seq;

  localparam int W  = 24;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_dz;
  logic [W-1:0]  a_num, a_den, a_q, a_r;
  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dz;
  logic [W8-1:0] b_num, b_den, b_q, b_r;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int vectors = 0;
  int errors  = 0;

  divider_seq #(.WIDTH(W)) dut_a (
    .clk(clk), .reset(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .numerator(a_num), .denominator(a_den),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .quotient(a_q), .remainder(a_r), .div_by_zero(a_dz)
  );

  divider_seq #(.WIDTH(W8)) dut_b (
    .clk(clk), .reset(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .numerator(b_num), .denominator(b_den),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .quotient(b_q), .remainder(b_r), .div_by_zero(b_dz)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d,
                                 input int width);
    exp_t e;
    logic [31:0] ones;
    ones = (width == 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (d == 0) begin
      e.q  = ones;
      e.r  = n;
      e.dz = 1'b1;
    end else begin
      e.q  = n / d;
      e.r  = n % d;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic accept_a(input logic [W-1:0] n, input logic [W-1:0] d);
    int g;
    g = 0;
    while (!a_in_ready && g < 100) begin
      tick();
      g++;
    end
    vectors++;
    if (!a_in_ready) begin
      errors++;
      $display("FAIL accept_a_ready: in_ready=%0b required 1", a_in_ready);
    end
    a_num = n;
    a_den = d;
    a_in_valid = 1'b1;
    sb_a.push_back(model({8'd0, n}, {8'd0, d}, W));
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic wait_out_a(output int lat);
    lat = 0;
    while (!a_out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic pop_a(input string tag);
    exp_t e;
    vectors++;
    if (sb_a.size() == 0 || !a_out_valid) begin
      errors++;
      $display("FAIL %s_pop: out_valid=%0b queued=%0d required 1 and >0",
               tag, a_out_valid, sb_a.size());
      return;
    end
    e = sb_a.pop_front();
    vectors++;
    if (a_q !== e.q[W-1:0]) begin
      errors++;
      $display("FAIL %s_quotient: got %h required %h", tag, a_q, e.q[W-1:0]);
    end
    vectors++;
    if (a_r !== e.r[W-1:0]) begin
      errors++;
      $display("FAIL %s_remainder: got %h required %h", tag, a_r, e.r[W-1:0]);
    end
    vectors++;
    if (a_dz !== e.dz) begin
      errors++;
      $display("FAIL %s_dz: got %b required %b", tag, a_dz, e.dz);
    end
  endtask

  task automatic release_a();
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0",
               a_in_ready, a_out_valid);
    end
    vectors++;
    if (a_q !== '0 || a_r !== '0 || a_dz !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: q=%h r=%h dz=%b required 0 0 0",
               a_q, a_r, a_dz);
    end
    vectors++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs8: in_ready=%b out_valid=%b required 1 0",
               b_in_ready, b_out_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    accept_a(24'd1000, 24'd7);
    vectors++;
    if (a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: in_ready=%b required 0", a_in_ready);
    end
    wait_out_a(lat);
    vectors++;
    if (lat != W) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges required %0d", lat, W);
    end
    pop_a("basic");
    release_a();
  endtask

  task automatic test_div_zero();
    int lat;
    accept_a(24'd5, 24'd0);
    wait_out_a(lat);
    vectors++;
    if (lat != 0) begin
      errors++;
      $display("FAIL dz_latency: got %0d extra edges required 0", lat);
    end
    pop_a("divzero");
    release_a();
  endtask

  task automatic test_edges();
    int lat;
    accept_a(24'hFFFFFF, 24'd1);
    wait_out_a(lat);
    pop_a("max_by_one");
    release_a();
    accept_a(24'd3, 24'd10);
    wait_out_a(lat);
    pop_a("small_num");
    release_a();
    accept_a(24'hFFFFFF, 24'hFFFFFF);
    wait_out_a(lat);
    pop_a("equal");
    release_a();
  endtask

  task automatic test_back_to_back();
    int lat;
    accept_a(24'd1000, 24'd7);
    wait_out_a(lat);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 ||
          a_q !== 24'd142 || a_r !== 24'd6 || a_dz !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: ov=%b ir=%b q=%0d r=%0d dz=%b required 1 0 142 6 0",
                 i, a_out_valid, a_in_ready, a_q, a_r, a_dz);
      end
    end
    pop_a("hold");
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_num       = 24'd9;
    a_den       = 24'd2;
    tick();
    a_out_ready = 1'b0;
    vectors++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_q !== 24'd142) begin
      errors++;
      $display("FAIL release: ir=%b ov=%b q=%0d required 1 0 142",
               a_in_ready, a_out_valid, a_q);
    end
    sb_a.push_back(model(32'd9, 32'd2, W));
    tick();
    a_in_valid = 1'b0;
    wait_out_a(lat);
    vectors++;
    if (lat != W) begin
      errors++;
      $display("FAIL b2b_latency: got %0d required %0d", lat, W);
    end
    pop_a("b2b");
    release_a();
  endtask

  task automatic test_reset_mid();
    bit seen;
    accept_a(24'd1000, 24'd7);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 ||
        a_q !== '0 || a_r !== '0 || a_dz !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: ir=%b ov=%b q=%h r=%h dz=%b required 1 0 0 0 0",
               a_in_ready, a_out_valid, a_q, a_r, a_dz);
    end
    void'(sb_a.pop_front());
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (a_out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ghost: out_valid seen=%b required 0", seen);
    end
  endtask

  function automatic logic [W8-1:0] pick8();
    logic [W8-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 8'd0;
      1:       v = 8'd255;
      default: v = W8'($urandom_range(0, 255));
    endcase
    return v;
  endfunction

  task automatic test_random8();
    exp_t e;
    int   g;
    for (int k = 0; k < 3000; k++) begin
      g = 0;
      while (!b_in_ready && g < 50) begin
        tick();
        g++;
      end
      b_num = pick8();
      b_den = pick8();
      b_in_valid = 1'b1;
      sb_b.push_back(model({24'd0, b_num}, {24'd0, b_den}, W8));
      tick();
      b_in_valid = 1'b0;
      g = 0;
      while (!b_out_valid && g < 50) begin
        tick();
        g++;
      end
      repeat ($urandom_range(0, 2)) tick();
      vectors++;
      if (!b_out_valid || sb_b.size() == 0) begin
        errors++;
        $display("FAIL rnd_timeout_%0d: out_valid=%b required 1", k, b_out_valid);
        sb_b.delete();
      end else begin
        e = sb_b.pop_front();
        vectors++;
        if (b_q !== e.q[W8-1:0] || b_r !== e.r[W8-1:0] || b_dz !== e.dz) begin
          errors++;
          $display("FAIL rnd_%0d: q=%0d r=%0d dz=%b required %0d %0d %b",
                   k, b_q, b_r, b_dz, e.q[W8-1:0], e.r[W8-1:0], e.dz);
        end
      end
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
    end
  endtask

  initial begin
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_num       = '0;
    a_den       = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_num       = '0;
    b_den       = '0;
    test_reset();
    test_basic();
    test_div_zero();
    test_edges();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
